imem_program_loader: RTL

- Writer side of the processor's 16-bit instruction memory: receives a framed byte stream, assembles 16-bit instruction words ([15:12] opcode, [11:8] rs, [7:4] rt, [3:0] rd), and writes them sequentially into instruction memory.
- Holds the pipeline core in reset while loading. Releases the core only after a verified load.
- Sits between a byte source (UART receiver or testbench) and the core's instruction-memory write port.

---
 rtl/imem_program_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/imem_program_loader.sv
// Instruction-memory loader: parses SYNC/COUNT/payload/CHK frames from a byte
// stream, writes 16-bit words sequentially and gates the core reset on a verified load.
module imem_program_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [15:0] imem_wdata,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [8:0]  words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic [2:0]  r_state;
  logic [8:0]  r_count;
  logic [8:0]  r_index;
  logic [7:0]  r_chk;
  logic [7:0]  r_hi;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [15:0] r_wdata;
  logic        r_coreReset;
  logic        r_done;
  logic        r_err;
  logic [8:0]  r_words;

  logic        w_fire;
  logic        w_isSync;
  logic [8:0]  w_indexNext;

  // The loader never back-pressures the source, so every valid byte is a handshake.
  assign in_ready    = 1'b1;
  assign w_fire      = in_valid & in_ready;
  assign w_isSync    = (in_data == SYNC_BYTE);
  assign w_indexNext = r_index + 9'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= 9'd0;
      r_index     <= 9'd0;
      r_chk       <= 8'd0;
      r_hi        <= 8'd0;
      r_we        <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_wdata     <= 16'd0;
      r_coreReset <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_words     <= 9'd0;
    end else begin
      r_we <= 1'b0;
      if (w_fire) begin
        case (r_state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (w_isSync) begin
              r_state     <= S_COUNT;
              r_coreReset <= 1'b1;
              r_done      <= 1'b0;
              r_err       <= 1'b0;
            end
          end
          S_COUNT: begin
            r_count <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            r_index <= 9'd0;
            r_chk   <= 8'd0;
            r_words <= 9'd0;
            r_state <= S_HI;
          end
          S_HI: begin
            r_hi    <= in_data;
            r_chk   <= r_chk ^ in_data;
            r_state <= S_LO;
          end
          S_LO: begin
            // Address wraps modulo 256 even though the index reaches 256.
            r_chk   <= r_chk ^ in_data;
            r_we    <= 1'b1;
            r_addr  <= BASE_ADDR + r_index[7:0];
            r_wdata <= {r_hi, in_data};
            r_index <= w_indexNext;
            r_words <= r_words + 9'd1;
            r_state <= (w_indexNext == r_count) ? S_CHECK : S_HI;
          end
          S_CHECK: begin
            if (in_data == r_chk) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_err       <= 1'b0;
              r_coreReset <= 1'b0;
            end else begin
              r_state     <= S_ERROR;
              r_done      <= 1'b0;
              r_err       <= 1'b1;
              r_coreReset <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign core_reset   = r_coreReset;
  assign load_done    = r_done;
  assign load_error   = r_err;
  assign words_loaded = r_words;

endmodule
